// File: rtl/ariane_pkg.sv
// Core-wide configuration constants shared by the data cache and its helpers.
package ariane_pkg;

  // Data cache geometry.
  localparam int unsigned DCACHE_NUM_SETS  = 256;
  localparam int unsigned DCACHE_SET_ASSOC = 8;

endpackage : ariane_pkg

// File: rtl/lzc.sv
// Leading/trailing zero counter. MODE=0 counts trailing zeros, which equals the
// index of the lowest set bit; MODE=1 counts leading zeros. Returns 0 when empty.
module lzc #(
  parameter int unsigned WIDTH = 2,
  parameter bit          MODE  = 1'b0,
  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [CntW-1:0]  cnt_o,
  output logic             empty_o
);

  // Priority scan: the last match in loop order wins.
  always_comb begin
    cnt_o = '0;
    if (MODE) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (in_i[i]) cnt_o = CntW'(int'(WIDTH) - 1 - i);
      end
    end else begin
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
        if (in_i[i]) cnt_o = CntW'(i);
      end
    end
  end

  assign empty_o = ~|in_i;

endmodule : lzc

// File: rtl/dcache_flush_unit.sv
// Walks every data cache set: reads valid/dirty state, issues one writeback per
// dirty valid way, waits for the writeback unit to drain, then invalidates the
// set. Acknowledges once after the last set and waits for the request to drop.
module dcache_flush_unit import ariane_pkg::*; #(
  parameter int unsigned NumSets = DCACHE_NUM_SETS,
  parameter int unsigned NumWays = DCACHE_SET_ASSOC,
  localparam int unsigned IdxW = $clog2(NumSets),
  localparam int unsigned WayW = (NumWays > 1) ? $clog2(NumWays) : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  output logic               flush_ack_o,
  output logic               busy_o,
  output logic               tag_req_o,
  input  logic               tag_gnt_i,
  output logic               tag_we_o,
  output logic [IdxW-1:0]    tag_idx_o,
  input  logic [NumWays-1:0] valid_bits_i,
  input  logic [NumWays-1:0] dirty_bits_i,
  output logic               wb_valid_o,
  input  logic               wb_ready_i,
  output logic [IdxW-1:0]    wb_idx_o,
  output logic [WayW-1:0]    wb_way_o,
  input  logic               wb_idle_i
);

  typedef enum logic [3:0] {
    IDLE, READ, CHECK, WB, WAIT_WB, INV, NEXT, ACK, DRAIN
  } state_e;

  state_e             r_state, w_state_next;
  logic [IdxW-1:0]    r_cnt, w_cnt_next;
  logic [NumWays-1:0] r_mask, w_mask_next;
  logic [NumWays-1:0] w_clear;
  logic [WayW-1:0]    w_way;
  logic               w_empty;

  // Lowest pending way is written back first.
  lzc #(
    .WIDTH (NumWays),
    .MODE  (1'b0)
  ) i_way_lzc (
    .in_i    (r_mask),
    .cnt_o   (w_way),
    .empty_o (w_empty)
  );

  // One-hot of the way currently being written back, used to retire it.
  for (genvar gi = 0; gi < int'(NumWays); gi++) begin : g_clear
    assign w_clear[gi] = (w_way == WayW'(gi));
  end

  // State, set counter and pending-writeback mask registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_mask  <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_mask  <= w_mask_next;
    end
  end

  // Next-state and output decode; outputs depend only on registered state.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_mask_next  = r_mask;
    flush_ack_o  = 1'b0;
    busy_o       = (r_state != IDLE);
    tag_req_o    = 1'b0;
    tag_we_o     = 1'b0;
    tag_idx_o    = r_cnt;
    wb_valid_o   = 1'b0;
    wb_idx_o     = r_cnt;
    wb_way_o     = w_way;

    unique case (r_state)
      IDLE: begin
        if (flush_i) begin
          w_state_next = READ;
          w_cnt_next   = '0;
        end
      end
      READ: begin
        tag_req_o = 1'b1;
        if (tag_gnt_i) w_state_next = CHECK;
      end
      CHECK: begin
        // Array data for the granted read is valid in this cycle.
        w_mask_next  = valid_bits_i & dirty_bits_i;
        w_state_next = (|(valid_bits_i & dirty_bits_i)) ? WB : INV;
      end
      WB: begin
        if (w_empty) begin
          w_state_next = WAIT_WB;
        end else begin
          wb_valid_o = 1'b1;
          if (wb_ready_i) begin
            w_mask_next = r_mask & ~w_clear;
            if (~|(r_mask & ~w_clear)) w_state_next = WAIT_WB;
          end
        end
      end
      WAIT_WB: begin
        // Invalidate only after all writebacks of this set have left the unit.
        if (wb_idle_i) w_state_next = INV;
      end
      INV: begin
        tag_req_o = 1'b1;
        tag_we_o  = 1'b1;
        if (tag_gnt_i) w_state_next = NEXT;
      end
      NEXT: begin
        if (r_cnt == IdxW'(NumSets - 1)) begin
          w_state_next = ACK;
        end else begin
          w_cnt_next   = r_cnt + 1'b1;
          w_state_next = READ;
        end
      end
      ACK: begin
        flush_ack_o  = 1'b1;
        w_state_next = DRAIN;
      end
      DRAIN: begin
        // A request still held high after the ack must not start another walk.
        if (!flush_i) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

endmodule : dcache_flush_unit

// File: doc/dcache_flush_unit.md
DCACHE_FLUSH_UNIT -- requirements
Module: dcache_flush_unit

Interface
REQ-001 SHALL have parameter NumSets, default ariane_pkg::DCACHE_NUM_SETS (power of 2, >=2), number of cache sets.
REQ-002 SHALL have parameter NumWays, default ariane_pkg::DCACHE_SET_ASSOC (>=1), number of ways per set.
REQ-003 SHALL have ports, one per line: name  direction  width  meaning:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- flush_i  in  1  flush request level from flush controller, held until ack
- flush_ack_o  out  1  one-cycle pulse, whole-cache flush complete
- busy_o  out  1  high in every state except IDLE
- tag_req_o  out  1  tag/state array access request
- tag_gnt_i  in  1  array grant, same cycle as request
- tag_we_o  out  1  access is invalidating write (all ways: valid=0, dirty=0)
- tag_idx_o  out  $clog2(NumSets)  set index of access
- valid_bits_i  in  NumWays  valid bits, one cycle after granted read
- dirty_bits_i  in  NumWays  dirty bits, one cycle after granted read
- wb_valid_o  out  1  writeback request to miss/writeback unit
- wb_ready_i  in  1  writeback request accepted
- wb_idx_o  out  $clog2(NumSets)  writeback set index
- wb_way_o  out  $clog2(NumWays) (min 1)  writeback way
- wb_idle_i  in  1  no writeback outstanding in writeback unit

Function
REQ-004 SHALL implement FSM states IDLE, READ, CHECK, WB, WAIT_WB, INV, NEXT, ACK, DRAIN.
REQ-005 IDLE: flush_i=1 -> READ next cycle with set index counter cleared to 0; flush_i=0 -> stay.
REQ-006 READ: tag_req_o=1, tag_we_o=0, tag_idx_o=counter; tag_gnt_i=1 -> CHECK, else stay READ with outputs held.
REQ-007 CHECK: capture pending mask = valid_bits_i AND dirty_bits_i; mask nonzero -> WB, zero -> INV.
REQ-008 WB: wb_valid_o=1, wb_idx_o=counter, wb_way_o=lowest-index set bit of pending mask; outputs stable until wb_ready_i.
REQ-009 WB handshake: on wb_valid_o AND wb_ready_i clear that mask bit; remaining mask nonzero -> stay WB (next way issued next cycle), else -> WAIT_WB.
REQ-010 WAIT_WB: wb_idle_i=1 -> INV, else stay.
REQ-011 INV: tag_req_o=1, tag_we_o=1, tag_idx_o=counter; tag_gnt_i=1 -> NEXT, else stay.
REQ-012 NEXT: counter == NumSets-1 -> ACK; else counter+1 -> READ; counter never wraps during a flush.
REQ-013 ACK: flush_ack_o=1 exactly this one cycle -> DRAIN.
REQ-014 DRAIN: wait until flush_i=0 (controller deasserts up to 2 cycles after ack), then -> IDLE; flush_i held high SHALL NOT start a second flush.
REQ-015 flush_i SHALL be sampled only in IDLE and DRAIN; deassertion mid-flush does not abort the walk.
REQ-016 tag_req_o, wb_valid_o, flush_ack_o SHALL be 0 in all states not listed as driving them; tag_idx_o/wb_idx_o may hold counter otherwise.
REQ-017 Clean cache flush latency from flush_i rise to flush_ack_o SHALL be 4*NumSets+1 cycles with tag_gnt_i tied 1.

Reset
REQ-018 On rst_ni=0: state IDLE, counter 0, pending mask 0, all outputs 0; reset mid-flush abandons the walk without ack.

Structure
REQ-019 DCACHE_NUM_SETS and DCACHE_SET_ASSOC constants SHALL reside in ariane_pkg; FSM state enum local to module.
REQ-020 Way selection SHALL use one common_cells lzc instance (trailing-zero mode) on pending mask.

Verification (NumSets=4, NumWays=2, tag_gnt_i=1, wb_ready_i=1, wb_idle_i=1 unless stated)
REQ-021 All lines clean, flush_i raised at cycle 0 -> flush_ack_o single pulse at cycle 17, 4 invalidating writes idx 0..3.
REQ-022 Set 2 valid=2'b11 dirty=2'b11 -> wb requests (idx2,way0) then (idx2,way1) on consecutive cycles, then invalidate idx 2.
REQ-023 wb_ready_i low 5 cycles on first request -> wb_valid_o held, wb_idx_o/wb_way_o stable, no duplicate request.
REQ-024 flush_i held high 2 cycles after ack -> exactly one flush_ack_o, FSM returns IDLE, no new READ.
REQ-025 tag_gnt_i low 3 cycles in READ, wb_idle_i low 4 cycles in WAIT_WB -> states stall, no skipped set.
REQ-026 rst_ni asserted during WB of set 1 -> all outputs 0 next edge, new flush_i restarts at idx 0.
